// File: rtl/tag_lookup_ctrl.sv
// Direct-mapped tag lookup controller: drives the tag SRAM, holds per-line valid
// bits and returns hit/miss one cycle after issue. Optional statistics: TAG_STATS_EN.
module tag_lookup_ctrl #(
    parameter int unsigned TAG_W = 22,
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [IDX_W-1:0] resp_index,
    output logic [TAG_W-1:0] resp_tag,
    input  logic             fill_valid,
    output logic             fill_ready,
    input  logic [31:0]      fill_addr,
    input  logic             inv_all,
    output logic             TA_CS,
    output logic             TA_OE,
    output logic             TA_WEB,
    output logic [IDX_W-1:0] TA_A,
    output logic [TAG_W-1:0] TA_DI,
    input  logic [TAG_W-1:0] TA_DO
`ifdef TAG_STATS_EN
    ,
    output logic [15:0]      hit_cnt,
    output logic [15:0]      miss_cnt
`endif
);

    localparam int unsigned NLINES = 1 << IDX_W;
    localparam int unsigned OFF_W  = 4;

    logic              s1_valid;
    logic [IDX_W-1:0]  s1_index;
    logic [TAG_W-1:0]  s1_tag;
    logic [NLINES-1:0] valid;
    logic              req_fire;
    logic              fill_fire;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              unused_bits;

    assign req_idx  = req_addr[OFF_W +: IDX_W];
    assign req_tag  = req_addr[OFF_W + IDX_W +: TAG_W];
    assign fill_idx = fill_addr[OFF_W +: IDX_W];
    assign fill_tag = fill_addr[OFF_W + IDX_W +: TAG_W];
    assign unused_bits = ^{req_addr[OFF_W-1:0], fill_addr[OFF_W-1:0]};

    // Fill wins over a lookup; a fill waits for the compare stage to drain.
    assign req_ready  = rst_n & ~inv_all & ~fill_valid;
    assign fill_ready = rst_n & ~inv_all & ~s1_valid;
    assign req_fire   = req_valid & req_ready;
    assign fill_fire  = fill_valid & fill_ready;

    // S0: SRAM drive from whichever transaction is accepted this cycle.
    always_comb begin
        TA_CS  = 1'b0;
        TA_OE  = 1'b0;
        TA_WEB = 1'b1;
        TA_A   = '0;
        TA_DI  = '0;
        if (fill_fire) begin
            TA_CS  = 1'b1;
            TA_WEB = 1'b0;
            TA_A   = fill_idx;
            TA_DI  = fill_tag;
        end else if (req_fire) begin
            TA_CS = 1'b1;
            TA_OE = 1'b1;
            TA_A  = req_idx;
        end
    end

    // S1: compare stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_index <= '0;
            s1_tag   <= '0;
        end else begin
            s1_valid <= req_fire;
            if (req_fire) begin
                s1_index <= req_idx;
                s1_tag   <= req_tag;
            end
        end
    end

    // Valid bits: flush beats fill; the same-cycle compare sees pre-clear values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (inv_all) begin
            valid <= '0;
        end else if (fill_fire) begin
            valid[fill_idx] <= 1'b1;
        end
    end

    assign resp_valid = s1_valid;
    assign resp_index = s1_index;
    assign resp_tag   = s1_tag;
    // Invalid line short-circuits the tag compare so unknown read data never hits.
    assign resp_hit   = s1_valid && valid[s1_index] && (TA_DO == s1_tag);

`ifdef TAG_STATS_EN
    // Saturating hit/miss counters; flush does not clear them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (resp_valid) begin
            if (resp_hit) begin
                if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            end else begin
                if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Table-driven bench for tag_lookup_ctrl with a behavioural 64x22 tag SRAM.
module tb_tag_lookup_ctrl;

    localparam int unsigned TAG_W = 22;
    localparam int unsigned IDX_W = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_addr;
    logic             resp_valid;
    logic             resp_hit;
    logic [IDX_W-1:0] resp_index;
    logic [TAG_W-1:0] resp_tag;
    logic             fill_valid;
    logic             fill_ready;
    logic [31:0]      fill_addr;
    logic             inv_all;
    logic             TA_CS, TA_OE, TA_WEB;
    logic [IDX_W-1:0] TA_A;
    logic [TAG_W-1:0] TA_DI;
    logic [TAG_W-1:0] TA_DO;
`ifdef TAG_STATS_EN
    logic [15:0]      hit_cnt, miss_cnt;
`endif

    tag_lookup_ctrl #(.TAG_W(TAG_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_hit(resp_hit),
        .resp_index(resp_index), .resp_tag(resp_tag),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr),
        .inv_all(inv_all),
        .TA_CS(TA_CS), .TA_OE(TA_OE), .TA_WEB(TA_WEB),
        .TA_A(TA_A), .TA_DI(TA_DI), .TA_DO(TA_DO)
`ifdef TAG_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural tag SRAM: synchronous write, registered read.
    logic [TAG_W-1:0] mem [64];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        TA_DO = '0;
    end
    always @(posedge clk) begin
        if (TA_CS && !TA_WEB) mem[TA_A] <= TA_DI;
        else if (TA_CS && TA_OE) TA_DO <= mem[TA_A];
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int cur    = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %h, expected %h", name, cur, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rv;
        logic [31:0] ra;
        logic        fv;
        logic [31:0] fa;
        logic        inv;
        logic        e_rr;
        logic        e_fr;
        logic        e_rv;
        logic        e_hit;
        logic [5:0]  e_idx;
        logic [21:0] e_tag;
    } vec_t;

    vec_t vt [24];

    function automatic vec_t mk(input logic rv, input logic [31:0] ra, input logic fv,
                                input logic [31:0] fa, input logic inv, input logic e_rr,
                                input logic e_fr, input logic e_rv, input logic e_hit,
                                input logic [5:0] e_idx, input logic [21:0] e_tag);
        vec_t v;
        v.rv = rv; v.ra = ra; v.fv = fv; v.fa = fa; v.inv = inv;
        v.e_rr = e_rr; v.e_fr = e_fr; v.e_rv = e_rv; v.e_hit = e_hit;
        v.e_idx = e_idx; v.e_tag = e_tag;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic       exp_cs, exp_oe, exp_web;
        logic [5:0] exp_a;
        logic [21:0] exp_di;

        //           rv  ra           fv  fa           inv rr  fr  rv  hit idx    tag
        vt[0]  = mk(1, 32'h1230, 0, 32'h0,    0,  1,  1,  0,  0,  6'h00, 22'h0);
        vt[1]  = mk(0, 32'h0,    1, 32'h1230, 0,  0,  0,  1,  0,  6'h23, 22'h4);
        vt[2]  = mk(0, 32'h0,    1, 32'h1230, 0,  0,  1,  0,  0,  6'h23, 22'h4);
        vt[3]  = mk(1, 32'h123C, 0, 32'h0,    0,  1,  1,  0,  0,  6'h23, 22'h4);
        vt[4]  = mk(1, 32'h1630, 0, 32'h0,    0,  1,  0,  1,  1,  6'h23, 22'h4);
        vt[5]  = mk(1, 32'h1230, 1, 32'h400,  0,  0,  0,  1,  0,  6'h23, 22'h5);
        vt[6]  = mk(1, 32'h1230, 1, 32'h400,  0,  0,  1,  0,  0,  6'h23, 22'h5);
        vt[7]  = mk(1, 32'h1230, 0, 32'h0,    0,  1,  1,  0,  0,  6'h23, 22'h5);
        vt[8]  = mk(0, 32'h0,    1, 32'h410,  0,  0,  0,  1,  1,  6'h23, 22'h4);
        vt[9]  = mk(0, 32'h0,    1, 32'h410,  0,  0,  1,  0,  0,  6'h23, 22'h4);
        vt[10] = mk(0, 32'h0,    1, 32'h420,  0,  0,  1,  0,  0,  6'h23, 22'h4);
        vt[11] = mk(0, 32'h0,    1, 32'h430,  0,  0,  1,  0,  0,  6'h23, 22'h4);
        vt[12] = mk(1, 32'h400,  0, 32'h0,    0,  1,  1,  0,  0,  6'h23, 22'h4);
        vt[13] = mk(1, 32'h410,  0, 32'h0,    0,  1,  0,  1,  1,  6'h00, 22'h1);
        vt[14] = mk(1, 32'h420,  0, 32'h0,    0,  1,  0,  1,  1,  6'h01, 22'h1);
        vt[15] = mk(1, 32'h430,  0, 32'h0,    0,  1,  0,  1,  1,  6'h02, 22'h1);
        vt[16] = mk(0, 32'h0,    0, 32'h0,    0,  1,  0,  1,  1,  6'h03, 22'h1);
        vt[17] = mk(0, 32'h0,    0, 32'h0,    0,  1,  1,  0,  0,  6'h03, 22'h1);
        vt[18] = mk(0, 32'h0,    1, 32'h1450, 0,  0,  1,  0,  0,  6'h03, 22'h1);
        vt[19] = mk(1, 32'h1450, 0, 32'h0,    0,  1,  1,  0,  0,  6'h03, 22'h1);
        vt[20] = mk(0, 32'h0,    0, 32'h0,    1,  0,  0,  1,  1,  6'h05, 22'h5);
        vt[21] = mk(1, 32'h1450, 0, 32'h0,    0,  1,  1,  0,  0,  6'h05, 22'h5);
        vt[22] = mk(0, 32'h0,    0, 32'h0,    0,  1,  0,  1,  0,  6'h05, 22'h5);
        vt[23] = mk(0, 32'h0,    0, 32'h0,    0,  1,  1,  0,  0,  6'h05, 22'h5);

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0;
        fill_valid = 1'b0; fill_addr = '0; inv_all = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst fill_ready", 32'(fill_ready), 32'd0);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst TA", 32'({TA_CS, TA_OE, TA_WEB, TA_A, TA_DI}), 32'({3'b001, 6'h0, 22'h0}));
        cyc();
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            cur = i;
            req_valid = vt[i].rv; req_addr = vt[i].ra;
            fill_valid = vt[i].fv; fill_addr = vt[i].fa; inv_all = vt[i].inv;
            @(negedge clk);
            exp_cs = 1'b0; exp_oe = 1'b0; exp_web = 1'b1; exp_a = '0; exp_di = '0;
            if (vt[i].fv && vt[i].e_fr) begin
                exp_cs = 1'b1; exp_web = 1'b0;
                exp_a = vt[i].fa[9:4]; exp_di = vt[i].fa[31:10];
            end else if (vt[i].rv && vt[i].e_rr) begin
                exp_cs = 1'b1; exp_oe = 1'b1; exp_a = vt[i].ra[9:4];
            end
            chk("req_ready", 32'(req_ready), 32'(vt[i].e_rr));
            chk("fill_ready", 32'(fill_ready), 32'(vt[i].e_fr));
            chk("resp_valid", 32'(resp_valid), 32'(vt[i].e_rv));
            if (vt[i].e_rv) begin
                chk("resp_hit", 32'(resp_hit), 32'(vt[i].e_hit));
                chk("resp_index", 32'(resp_index), 32'(vt[i].e_idx));
                chk("resp_tag", 32'(resp_tag), 32'(vt[i].e_tag));
            end
            chk("TA drive", 32'({TA_CS, TA_OE, TA_WEB, TA_A, TA_DI}),
                32'({exp_cs, exp_oe, exp_web, exp_a, exp_di}));
            cyc();
        end
        req_valid = 1'b0; fill_valid = 1'b0; inv_all = 1'b0;
        cur = 100;

`ifdef TAG_STATS_EN
        chk("hit_cnt", 32'(hit_cnt), 32'd7);
        chk("miss_cnt", 32'(miss_cnt), 32'd3);
        // Flushed cache: a long burst of misses must saturate miss_cnt.
        req_addr = 32'h0;
        req_valid = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc();
        cur = 101;
        chk("miss_cnt sat", 32'(miss_cnt), 32'h0000FFFF);
        chk("hit_cnt hold", 32'(hit_cnt), 32'd7);
`endif

        // Reset mid-lookup: fill, issue a lookup, then assert reset before it responds.
        cur = 200;
        fill_valid = 1'b1; fill_addr = 32'h1230;
        cyc();
        fill_valid = 1'b0;
        req_valid = 1'b1; req_addr = 32'h1230;
        cyc();
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst mid resp_valid", 32'(resp_valid), 32'd0);
        chk("rst mid resp", 32'({resp_hit, resp_index, resp_tag}), 32'd0);
        chk("rst mid readies", 32'({req_ready, fill_ready}), 32'd0);
        chk("rst mid TA", 32'({TA_CS, TA_OE, TA_WEB, TA_A, TA_DI}), 32'({3'b001, 6'h0, 22'h0}));
`ifdef TAG_STATS_EN
        chk("rst mid cnt", 32'({hit_cnt, miss_cnt}), 32'd0);
`endif
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        cur = 201;
        chk("post rst req_ready", 32'(req_ready), 32'd1);
        chk("post rst resp_valid", 32'(resp_valid), 32'd0);
        // Reset cleared the valid bit even though the SRAM still holds the tag.
        req_valid = 1'b1; req_addr = 32'h1230;
        cyc();
        req_valid = 1'b0;
        @(negedge clk);
        cur = 202;
        chk("post rst resp_valid", 32'(resp_valid), 32'd1);
        chk("post rst miss", 32'(resp_hit), 32'd0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
